// File: rtl/nios_system_pio_in_capture_pkg.sv
// Shared constants for the Avalon-MM input-capture PIO: register map and
// edge-type selection codes.
package nios_pio_pkg;

    // Word addresses on the Avalon-MM slave port (address 1 is reserved)
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Which transition of a synchronized input bit sets its capture bit
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_system_pio_in_capture_if.sv
// Avalon-MM slave bus bundle for the input-capture PIO.
//
// Handshake: a transfer happens in every clock cycle in which chipselect is
// high. write_n low makes it a write that commits at that clock edge; write_n
// high makes it a read. readdata is a combinational function of address and is
// valid in the same cycle (zero wait states, no waitrequest, reads have no side
// effects).
interface nios_system_pio_in_capture_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/nios_system_pio_in_capture_sync_edge.sv
// Input synchronizer, previous-sample register and edge detector.
// Edge reporting stays gated off until the priming counter has run past the
// synchronizer depth, so levels already present at reset release never look
// like edges.
module pio_sync_edge
    import nios_pio_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_in_port,
    output logic [WIDTH-1:0] o_sample,
    output logic [WIDTH-1:0] o_edge_now
);

    localparam logic [2:0] PRIME_CNT = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [2:0]       r_cnt;
    logic             r_primed;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_sel;

    // Shift the asynchronous inputs through the synchronizer chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_sample = r_sync[SYNC_STAGES-1];

    // Keep the previous synchronized sample for edge comparison
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= o_sample;
        end
    end

    // Count cycles after reset release until the chain and prev hold real data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= 3'd0;
            r_primed <= 1'b0;
        end else if (!r_primed) begin
            if (r_cnt == PRIME_CNT) begin
                r_primed <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    assign w_rise = o_sample & ~r_prev;
    assign w_fall = ~o_sample & r_prev;

    // Pick the transition type that counts as an edge
    always_comb begin
        w_sel = '0;
        case (EDGE_TYPE)
            EDGE_RISE: w_sel = w_rise;
            EDGE_FALL: w_sel = w_fall;
            default:   w_sel = w_rise | w_fall;
        endcase
    end

    assign o_edge_now = r_primed ? w_sel : '0;

endmodule

// File: rtl/nios_system_pio_in_capture.sv
// Avalon-MM input PIO with sticky edge capture and optional level interrupt.
// Register map: 0=DATA (synchronized input), 1=reserved (reads 0),
// 2=IRQMASK, 3=EDGECAP (write-1-to-clear, a same-cycle new edge wins).
// Build option: define NIOS_PIO_IN_IRQ_EN to implement IRQMASK and irq;
// without it address 2 reads 0, its writes are dropped and irq is tied low.
module nios_system_pio_in_capture
    import nios_pio_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    nios_system_pio_in_capture_if.slave    bus,
    input  logic [WIDTH-1:0]               in_port,
    output logic                           irq
);

    logic [WIDTH-1:0] w_sample;
    logic [WIDTH-1:0] w_edge_now;
    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_edgecap_next;
    logic [WIDTH-1:0] w_irqmask_rd;
    logic [WIDTH-1:0] r_edgecap;
    logic             w_unused_wd;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_in_port  (in_port),
        .o_sample   (w_sample),
        .o_edge_now (w_edge_now)
    );

    assign w_wr  = bus.chipselect & ~bus.write_n;
    assign w_wd  = bus.writedata[WIDTH-1:0];
    // Upper write-data bits have no storage behind them
    assign w_unused_wd = ^bus.writedata;

    assign w_clr          = (w_wr && (bus.address == ADDR_EDGECAP)) ? w_wd : '0;
    assign w_edgecap_next = (r_edgecap & ~w_clr) | w_edge_now;

    // Sticky edge-capture register: clear on written ones, new edges override
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= w_edgecap_next;
        end
    end

`ifdef NIOS_PIO_IN_IRQ_EN
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] w_irqmask_next;
    logic             r_irq;

    assign w_irqmask_next = (w_wr && (bus.address == ADDR_IRQMASK)) ? w_wd : r_irqmask;

    // Mask register and registered interrupt, both computed from next-state
    // values so a clear or unmask takes effect on irq in one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_irqmask <= w_irqmask_next;
            r_irq     <= |(w_edgecap_next & w_irqmask_next);
        end
    end

    assign w_irqmask_rd = r_irqmask;
    assign irq          = r_irq;
`else
    assign w_irqmask_rd = '0;
    assign irq          = 1'b0;
`endif

    // Zero-wait-state read mux, zero-extended to 32 bits
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:    bus.readdata[WIDTH-1:0] = w_sample;
            ADDR_IRQMASK: bus.readdata[WIDTH-1:0] = w_irqmask_rd;
            ADDR_EDGECAP: bus.readdata[WIDTH-1:0] = r_edgecap;
            default:      bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_system_pio_in_capture.sv
// Directed bench for the input-capture PIO. Two instances share clock and
// reset: dut0 detects rising edges, dut2 detects any edge.
module tb_nios_system_pio_in_capture;
    import nios_pio_pkg::*;

    localparam int W = 10;
`ifdef NIOS_PIO_IN_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] in0;
    logic [W-1:0] in2;
    logic         irq0;
    logic         irq2;

    always #5 clk = ~clk;

    nios_system_pio_in_capture_if bus0 ();
    nios_system_pio_in_capture_if bus2 ();

    nios_system_pio_in_capture #(.WIDTH(W), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(2)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0),
        .in_port (in0),
        .irq     (irq0)
    );

    nios_system_pio_in_capture #(.WIDTH(W), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2),
        .in_port (in2),
        .irq     (irq2)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic check_pop(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: observed %h but no expected value queued", tag, obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, e);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input int sel, input logic [1:0] a, output logic [31:0] d);
        if (sel == 0) begin
            bus0.address = a; bus0.chipselect = 1'b1; bus0.write_n = 1'b1;
        end else begin
            bus2.address = a; bus2.chipselect = 1'b1; bus2.write_n = 1'b1;
        end
        #1;
        d = (sel == 0) ? bus0.readdata : bus2.readdata;
        bus0.chipselect = 1'b0;
        bus2.chipselect = 1'b0;
    endtask

    task automatic wr(input int sel, input logic [1:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus0.address = a; bus0.writedata = d; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
        end else begin
            bus2.address = a; bus2.writedata = d; bus2.chipselect = 1'b1; bus2.write_n = 1'b0;
        end
        @(posedge clk);
        #1;
        bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
        bus2.chipselect = 1'b0; bus2.write_n = 1'b1;
    endtask

    task automatic exp_reg(input int sel, input logic [1:0] a, input logic [31:0] e,
                           input string tag);
        logic [31:0] d;
        exp_q.push_back(e);
        rd(sel, a, d);
        check_pop(tag, d);
    endtask

    task automatic exp_irq(input int sel, input logic e, input string tag);
        exp_q.push_back({31'd0, e});
        check_pop(tag, {31'd0, (sel == 0) ? irq0 : irq2});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [W-1:0] cur;
        logic [W-1:0] v;
        logic [W-1:0] cap;

        reset_n = 1'b0;
        in0 = 10'h3FF;
        in2 = '0;
        bus0.address = '0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
        bus2.address = '0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = '0;

        // 1: input held high through reset release
        tick(3);
        exp_reg(0, ADDR_DATA,    32'h0, "rst_data");
        exp_reg(0, ADDR_EDGECAP, 32'h0, "rst_edgecap");
        exp_irq(0, 1'b0, "rst_irq");
        reset_n = 1'b1;
        tick(1);
        exp_reg(0, ADDR_DATA, 32'h0, "sync_data_p1");
        tick(1);
        exp_reg(0, ADDR_DATA, 32'h3FF, "sync_data_p2");
        tick(6);
        exp_reg(0, ADDR_EDGECAP, 32'h0, "held_no_cap");
        exp_irq(0, 1'b0, "held_no_irq");

        // 2: rising edge capture latency and stickiness (falls ignored)
        in0 = '0;
        tick(5);
        exp_reg(0, ADDR_EDGECAP, 32'h0, "fall_ignored");
        in0 = 10'h005;
        tick(2);
        exp_reg(0, ADDR_DATA,    32'h005, "rise_data_p2");
        exp_reg(0, ADDR_EDGECAP, 32'h000, "rise_cap_p2");
        tick(1);
        exp_reg(0, ADDR_EDGECAP, 32'h005, "rise_cap_p3");
        in0 = '0;
        tick(4);
        exp_reg(0, ADDR_DATA,    32'h000, "data_back_0");
        exp_reg(0, ADDR_EDGECAP, 32'h005, "cap_sticky");

        // 3: interrupt on a masked bit, clear-to-deassert
        wr(0, ADDR_EDGECAP, 32'h004);
        exp_reg(0, ADDR_EDGECAP, 32'h001, "w1c_bit2");
        wr(0, ADDR_IRQMASK, 32'h004);
        exp_reg(0, ADDR_IRQMASK, IRQ_EN ? 32'h004 : 32'h0, "irqmask_rd");
        exp_irq(0, 1'b0, "irq_masked_idle");
        in0 = 10'h004;
        tick(1);
        in0 = '0;
        tick(1);
        exp_irq(0, 1'b0, "irq_p2");
        tick(1);
        exp_irq(0, IRQ_EN, "irq_p3");
        exp_reg(0, ADDR_EDGECAP, 32'h005, "cap_pulse");
        wr(0, ADDR_EDGECAP, 32'h004);
        exp_irq(0, 1'b0, "irq_cleared");
        exp_reg(0, ADDR_EDGECAP, 32'h001, "cap_after_clr");

        // 4: clear and new edge on the same bit in the same cycle
        in0 = 10'h001;
        tick(2);
        wr(0, ADDR_EDGECAP, 32'h001);
        exp_reg(0, ADDR_EDGECAP, 32'h001, "set_wins");
        wr(0, ADDR_EDGECAP, 32'h001);
        exp_reg(0, ADDR_EDGECAP, 32'h000, "plain_clear");
        in0 = '0;
        tick(4);

        // random input patterns against a rising-edge model
        cur = '0;
        cap = '0;
        for (int i = 0; i < 6; i++) begin
            v = W'($urandom_range(0, 1023));
            in0 = v;
            tick(2);
            exp_reg(0, ADDR_DATA, {22'd0, v}, "rand_data");
            tick(1);
            cap = cap | (v & ~cur);
            cur = v;
        end
        exp_reg(0, ADDR_EDGECAP, {22'd0, cap}, "rand_cap");
        in0 = '0;
        tick(4);
        wr(0, ADDR_EDGECAP, 32'h3FF);
        exp_reg(0, ADDR_EDGECAP, 32'h0, "rand_clear");

        // 5: any-edge instance, reserved address, ignored writes
        in2 = 10'h200;
        tick(3);
        exp_reg(2, ADDR_EDGECAP, 32'h200, "any_rise");
        wr(2, ADDR_EDGECAP, 32'h200);
        exp_reg(2, ADDR_EDGECAP, 32'h000, "any_clear");
        in2 = '0;
        tick(3);
        exp_reg(2, ADDR_EDGECAP, 32'h200, "any_fall");
        exp_reg(2, ADDR_RSVD, 32'h0, "rsvd2_rd");
        exp_reg(0, ADDR_RSVD, 32'h0, "rsvd0_rd");
        exp_irq(2, 1'b0, "any_no_mask_irq");
        wr(0, ADDR_DATA, 32'hFFFF_FFFF);
        wr(0, ADDR_RSVD, 32'hFFFF_FFFF);
        exp_reg(0, ADDR_EDGECAP, 32'h0, "ignored_wr_cap");
        exp_reg(0, ADDR_DATA,    32'h0, "ignored_wr_data");
        wr(0, ADDR_IRQMASK, 32'hFFFF_F000);
        exp_reg(0, ADDR_IRQMASK, 32'h0, "mask_upper_dropped");

        // 6: asynchronous reset mid-capture
        in0 = 10'h3FF;
        tick(3);
        exp_reg(0, ADDR_EDGECAP, 32'h3FF, "cap_all");
        wr(0, ADDR_IRQMASK, 32'h3FF);
        exp_irq(0, IRQ_EN, "irq_all");
        #2;
        reset_n = 1'b0;
        #1;
        exp_irq(0, 1'b0, "arst_irq");
        exp_reg(0, ADDR_EDGECAP, 32'h0, "arst_cap");
        exp_reg(0, ADDR_IRQMASK, 32'h0, "arst_mask");
        exp_reg(0, ADDR_DATA,    32'h0, "arst_data");
        exp_reg(2, ADDR_EDGECAP, 32'h0, "arst_cap2");
        tick(2);
        reset_n = 1'b1;
        tick(8);
        exp_reg(0, ADDR_DATA,    32'h3FF, "reprime_data");
        exp_reg(0, ADDR_EDGECAP, 32'h0,   "reprime_no_cap");
        exp_irq(0, 1'b0, "reprime_irq");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
